grf_wb: RTL and testbench
=========================

// Module: grf_wb
// PURPOSE
//   General register file: 32 x 32-bit, two combinational read ports, one
//   synchronous write port. Sits directly downstream of the write-address
//   select mux: its RD_WA output drives WA here. WD comes from the write-back
//   data mux. RD1/RD2 feed the ALU operand path and the DM write-data path.
//   Write-back trace registers (LastWA/LastWD/WrCnt) support the testbench
//   commit checker.
// PARAMETERS
//   BYPASS   1   1: a read of the register being written this cycle returns WD
//                (write-through); 0: returns the stored (old) value
//   CNT_W    16  width of write-commit counter WrCnt
// PORTS
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high; clears all state
//   RA1       in   5      read address port 1 (instr[25:21], rs)
//   RA2       in   5      read address port 2 (instr[20:16], rt)
//   WA        in   5      write address, from write-address mux RD_WA
//   WD        in   32     write data
//   RegWrite  in   1      write enable
//   RD1       out  32     read data port 1
//   RD2       out  32     read data port 2
//   LastWA    out  5      address of most recent committed write
//   LastWD    out  32     data of most recent committed write
//   WrCnt     out  CNT_W  number of committed writes since reset
// BEHAVIOUR
//   - Reset (async, any time): regs[0..31] <= 0, LastWA <= 0, LastWD <= 0,
//     WrCnt <= 0. A write on the edge that coincides with reset is discarded.
//     RD1/RD2 read 0 for every address while reset is held.
//   - Commit condition: posedge clk, reset low, RegWrite=1, WA!=0.
//     On commit: regs[WA] <= WD; LastWA <= WA; LastWD <= WD;
//     WrCnt <= WrCnt+1 (mod 2^CNT_W, wraps to 0, no saturation).
//   - RegWrite=1 with WA=0: no state change, WrCnt does not increment.
//     $0 stays 0.
//   - Reads: combinational, zero latency. RAx=0 -> 0 regardless of BYPASS/WD.
//   - BYPASS=1 and RegWrite=1 and WA==RAx and WA!=0 -> RDx = WD (same cycle);
//     otherwise RDx = regs[RAx]. RA1 and RA2 are bypassed independently;
//     both may hit at once.
//   - BYPASS=0: a write is visible on RDx starting the cycle after the edge.
//   - Write latency: 1 edge. No stall/handshake; one write per cycle max.
//   - X on WA/WD with RegWrite=0 must not disturb state.
// TESTING
//   1 Reset: assert reset mid-cycle after writing $5=0x1234 -> RD1(RA1=5)=0
//     immediately, WrCnt=0, LastWA=0.
//   2 Write/read: RegWrite=1, WA=8, WD=0xDEADBEEF, edge; RA2=8 -> RD2=0xDEADBEEF,
//     LastWA=8, LastWD=0xDEADBEEF, WrCnt=1.
//   3 $0 guard: RegWrite=1, WA=0, WD=0xFFFFFFFF, edge -> RD1(RA1=0)=0,
//     WrCnt unchanged.
//   4 Bypass: BYPASS=1, $9=0x11; RegWrite=1, WA=9, WD=0x22, RA1=RA2=9 before
//     edge -> RD1=RD2=0x22; with BYPASS=0 -> RD1=RD2=0x11 until edge, then 0x22.
//   5 Wrap: CNT_W=4, commit 17 writes to $1..$17 cycling -> WrCnt=1, all 17
//     addresses (mod 32, skipping 0) hold written values.
//   6 Reset vs edge: reset rises coincident with RegWrite=1, WA=3, WD=0x55
//     edge -> regs[3]=0, WrCnt=0.

Source files
------------

// File: rtl/grf_wb.sv
// -----------------------------------------------------------------------------
// grf_wb -- general register file, 32 x 32-bit
//
// Two combinational read ports and one synchronous write port. Register $0 is
// hard-wired to zero. Optional write-through bypass lets a read of the
// register being written this cycle return the incoming write data. A small
// set of write-back trace registers records the most recent committed write
// and counts commits since reset.
//
// Parameters
//   BYPASS  1: same-cycle read of the register being written returns WD
//           0: reads return the stored value; a write shows up after the edge
//   CNT_W   width of the commit counter WrCnt (wraps, no saturation)
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high; clears all state
//   RA1, RA2  in   5      read addresses (rs, rt)
//   WA        in   5      write address (from the write-address mux)
//   WD        in   32     write data (from the write-back mux)
//   RegWrite  in   1      write enable
//   RD1, RD2  out  32     read data
//   LastWA    out  5      address of most recent committed write
//   LastWD    out  32     data of most recent committed write
//   WrCnt     out  CNT_W  committed writes since reset
// -----------------------------------------------------------------------------
module grf_wb #(
    parameter int BYPASS = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RA1,
    input  logic [4:0]       RA2,
    input  logic [4:0]       WA,
    input  logic [31:0]      WD,
    input  logic             RegWrite,
    output logic [31:0]      RD1,
    output logic [31:0]      RD2,
    output logic [4:0]       LastWA,
    output logic [31:0]      LastWD,
    output logic [CNT_W-1:0] WrCnt
);

    logic [31:0]      regs_q [32];
    logic [31:0]      regs_d [32];
    logic [4:0]       last_wa_q, last_wa_d;
    logic [31:0]      last_wd_q, last_wd_d;
    logic [CNT_W-1:0] wr_cnt_q,  wr_cnt_d;

    logic             commit;
    logic             hit1, hit2;
    logic [31:0]      rd1, rd2;

    // A write to $0 is not a commit: nothing changes and the counter holds.
    // With RegWrite low the AND short-circuits, so unknown WA/WD cannot leak
    // into state.
    assign commit = RegWrite && (WA != 5'd0);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        regs_d    = regs_q;
        last_wa_d = last_wa_q;
        last_wd_d = last_wd_q;
        wr_cnt_d  = wr_cnt_q;

        if (commit) begin
            regs_d[WA] = WD;
            last_wa_d  = WA;
            last_wd_d  = WD;
            wr_cnt_d   = wr_cnt_q + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // Async reset has priority, so a write on an edge that coincides with
    // reset is discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the register array is deliberately reset here; architected
            // state must read zero after reset, so this cannot map to a RAM
            // macro without a reset port.
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            last_wa_q <= '0;
            last_wd_q <= '0;
            wr_cnt_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // flops sample their inputs from before the edge.
            regs_q    <= regs_d;
            last_wa_q <= last_wa_d;
            last_wd_q <= last_wd_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    // Bypass needs RAx == WA with WA != 0; the RAx == 0 override below covers
    // the WA == 0 case, so the compare does not repeat it.
    assign hit1 = (BYPASS != 0) && RegWrite && (WA == RA1);
    assign hit2 = (BYPASS != 0) && RegWrite && (WA == RA2);

    always_comb begin
        rd1 = regs_q[RA1];
        if (hit1) begin
            rd1 = WD;
        end
        // Reset forces zero even while a write to the read address is pending,
        // since bypass would otherwise expose WD during reset.
        if (reset || (RA1 == 5'd0)) begin
            rd1 = '0;
        end
    end

    always_comb begin
        rd2 = regs_q[RA2];
        if (hit2) begin
            rd2 = WD;
        end
        if (reset || (RA2 == 5'd0)) begin
            rd2 = '0;
        end
    end

    assign RD1    = rd1;
    assign RD2    = rd2;
    assign LastWA = last_wa_q;
    assign LastWD = last_wd_q;
    assign WrCnt  = wr_cnt_q;

endmodule

// File: tb/tb_grf_wb.sv
// -----------------------------------------------------------------------------
// tb_grf_wb -- bench for grf_wb
//
// Two instances share every input: dut_a uses write-through bypass and a
// 16-bit counter, dut_b has no bypass and a 4-bit counter (to see the wrap).
// A behavioural model (plain array, integer commit count) predicts reads and
// trace outputs for both.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_grf_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] wd;
    logic        we;

    logic [31:0] rd1_a, rd2_a, lwd_a;
    logic [4:0]  lwa_a;
    logic [15:0] cnt_a;
    logic [31:0] rd1_b, rd2_b, lwd_b;
    logic [4:0]  lwa_b;
    logic [3:0]  cnt_b;

    int checks   = 0;
    int failures = 0;

    // Reference model
    logic [31:0] mdl_regs [32];
    int unsigned mdl_cnt;
    logic [4:0]  mdl_lwa;
    logic [31:0] mdl_lwd;

    always #5 clk = ~clk;

    grf_wb #(.BYPASS(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .RA1(ra1), .RA2(ra2), .WA(wa), .WD(wd),
        .RegWrite(we), .RD1(rd1_a), .RD2(rd2_a), .LastWA(lwa_a),
        .LastWD(lwd_a), .WrCnt(cnt_a)
    );

    grf_wb #(.BYPASS(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .RA1(ra1), .RA2(ra2), .WA(wa), .WD(wd),
        .RegWrite(we), .RD1(rd1_b), .RD2(rd2_b), .LastWA(lwa_b),
        .LastWD(lwd_b), .WrCnt(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit bypass);
        if (reset || ra == 5'd0) return 32'h0;
        if (bypass && we && wa == ra) return wd;
        return mdl_regs[ra];
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < 32; i++) mdl_regs[i] = 32'h0;
        mdl_cnt = 0;
        mdl_lwa = 5'd0;
        mdl_lwd = 32'h0;
    endtask

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2,
                         input logic w, input logic [4:0] a, input logic [31:0] d);
        ra1 = r1; ra2 = r2; we = w; wa = a; wd = d;
    endtask

    task automatic check_reads(input string tag);
        #1;
        check({tag, ":rd1_a"}, rd1_a, exp_rd(ra1, 1'b1));
        check({tag, ":rd2_a"}, rd2_a, exp_rd(ra2, 1'b1));
        check({tag, ":rd1_b"}, rd1_b, exp_rd(ra1, 1'b0));
        check({tag, ":rd2_b"}, rd2_b, exp_rd(ra2, 1'b0));
    endtask

    task automatic check_trace(input string tag);
        check({tag, ":lwa_a"}, 32'(lwa_a), 32'(mdl_lwa));
        check({tag, ":lwd_a"}, lwd_a, mdl_lwd);
        check({tag, ":cnt_a"}, 32'(cnt_a), mdl_cnt % 65536);
        check({tag, ":lwa_b"}, 32'(lwa_b), 32'(mdl_lwa));
        check({tag, ":lwd_b"}, lwd_b, mdl_lwd);
        check({tag, ":cnt_b"}, 32'(cnt_b), mdl_cnt % 16);
    endtask

    // One rising edge; the model applies the commit rule to the inputs that
    // were stable across the edge, then outputs are sampled 2 ns later.
    task automatic tick(input string tag);
        @(posedge clk);
        if (reset) begin
            mdl_clear();
        end else if (we && wa != 5'd0) begin
            mdl_regs[wa] = wd;
            mdl_lwa = wa;
            mdl_lwd = wd;
            mdl_cnt++;
        end
        #2;
        check_trace(tag);
    endtask

    initial begin
        logic [4:0] a;
        mdl_clear();
        reset = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0);

        // Reset state, including a pending bypass-able write while reset held
        #2;
        drive(5'd7, 5'd31, 1'b1, 5'd7, 32'hA5A5A5A5);
        check_reads("rst_hold");
        check_trace("rst_hold");
        tick("rst_edge");
        @(negedge clk);
        reset = 1'b0;
        drive(5'd7, 5'd31, 1'b0, 5'd7, 32'h0);
        check_reads("rst_rel");

        // Test 1: write $5, then assert reset mid-cycle
        @(negedge clk);
        drive(5'd5, 5'd0, 1'b1, 5'd5, 32'h1234);
        tick("t1_wr");
        #1;
        drive(5'd5, 5'd5, 1'b0, 5'd0, 32'h0);
        check_reads("t1_pre");
        #1;
        reset = 1'b1;
        mdl_clear();
        check_reads("t1_rst");
        check_trace("t1_rst");
        @(negedge clk);
        reset = 1'b0;

        // Test 2: write/read $8
        @(negedge clk);
        drive(5'd0, 5'd8, 1'b1, 5'd8, 32'hDEADBEEF);
        check_reads("t2_pre");
        tick("t2_wr");
        #1;
        drive(5'd0, 5'd8, 1'b0, 5'd0, 32'h0);
        check_reads("t2_post");

        // Test 3: $0 guard
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        check_reads("t3_pre");
        tick("t3_wr");
        #1;
        check_reads("t3_post");

        // Test 4: bypass vs. no bypass
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b1, 5'd9, 32'h11);
        tick("t4_init");
        #1;
        drive(5'd9, 5'd9, 1'b1, 5'd9, 32'h22);
        check_reads("t4_same");
        tick("t4_wr");
        #1;
        drive(5'd9, 5'd9, 1'b0, 5'd0, 32'h0);
        check_reads("t4_after");

        // Unknown address/data with write disabled must not disturb state
        @(negedge clk);
        drive(5'd9, 5'd8, 1'b0, 'x, 'x);
        tick("x_idle");
        #1;
        drive(5'd9, 5'd8, 1'b0, 5'd0, 32'h0);
        check_reads("x_post");

        // Test 5: 17 commits to $1..$17 -> 4-bit counter wraps to 1
        @(negedge clk);
        reset = 1'b1;
        #1;
        mdl_clear();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            drive(5'd0, 5'd0, 1'b1, 5'(i), 32'h1000_0000 + 32'(i) * 32'h0101);
            tick("t5_wr");
            #1;
        end
        check("t5_cnt_b", 32'(cnt_b), 32'd1);
        check("t5_cnt_a", 32'(cnt_a), 32'd17);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        for (int i = 1; i <= 17; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(18 - i);
            check_reads("t5_rd");
        end

        // Randomised traffic against the model
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            a = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            drive(5'($urandom), 5'($urandom), 1'($urandom), a, $urandom);
            if ($urandom_range(0, 3) == 0) ra1 = a;
            if ($urandom_range(0, 3) == 0) ra2 = a;
            check_reads("rnd_pre");
            tick("rnd_wr");
        end

        // Test 6: reset rises on the same edge as a write to $3
        @(negedge clk);
        drive(5'd3, 5'd3, 1'b1, 5'd3, 32'h55);
        @(posedge clk);
        reset = 1'b1;
        mdl_clear();
        #2;
        check_trace("t6_rst");
        check_reads("t6_hold");
        @(negedge clk);
        reset = 1'b0;
        drive(5'd3, 5'd3, 1'b0, 5'd0, 32'h0);
        check_reads("t6_post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit reached");
    end

endmodule
